// File: rtl/mbus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mbus_pkg
// Purpose  : MBus constants and state encoding shared by member and master.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package mbus_pkg;

  localparam int                  c_addr_w     = 8;
  localparam logic [c_addr_w-1:0] c_bcast_addr = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4,
    ST_INTERJ = 3'd5
  } mbus_state_e;

endpackage
`default_nettype wire

// File: rtl/mbus_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mbus_sync_edge
// Purpose  : N-stage synchroniser (idles high) with rise/fall/change strobes.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mbus_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK_IN,
  input  logic RESET,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic change
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign sync_out = r_sync[STAGES-1];
  assign rise     = sync_out & ~r_prev;
  assign fall     = ~sync_out & r_prev;
  assign change   = sync_out ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/mbus_member_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mbus_member_rx
// Purpose  : MBus member receive front end: framing, address match, byte output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mbus_member_rx
  import mbus_pkg::*;
#(
  parameter int                  SYNC_STAGES    = 2,
  parameter int                  ARB_EDGES      = 2,
  parameter int                  INTERJ_TOGGLES = 3,
  parameter int                  IDLE_CYCLES    = 16,
  parameter logic [c_addr_w-1:0] BCAST_ADDR     = c_bcast_addr
) (
  input  logic                CLK_IN,
  input  logic                RESET,
  input  logic                BUS_CLK,
  input  logic                BUS_DIN,
  input  logic [c_addr_w-1:0] NODE_ADDR,
  output logic [c_addr_w-1:0] RX_DATA,
  output logic                RX_VALID,
  input  logic                RX_READY,
  output logic                RX_START,
  output logic                RX_END,
  output logic                RX_ERR,
  output logic                BUSY
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(INTERJ_TOGGLES + 1);
  localparam int EW = $clog2(ARB_EDGES + 1);
  localparam int BW = $clog2(c_addr_w);

  localparam logic [IW-1:0] c_idle_max = IW'(IDLE_CYCLES);
  localparam logic [TW-1:0] c_tog_last = TW'(INTERJ_TOGGLES - 1);
  localparam logic [EW-1:0] c_arb_last = EW'(ARB_EDGES - 1);

  logic w_sclk, w_sclk_rise, w_sclk_fall, w_sclk_chg;
  logic w_sdin, w_sdin_rise, w_sdin_fall, w_sdin_chg;
  logic w_unused_edges;

  mbus_state_e r_state, w_state_nxt;

  logic [IW-1:0]       r_idle_cnt;
  logic [EW-1:0]       r_edge_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [TW-1:0]       r_tog_cnt;
  logic [c_addr_w-1:0] r_shift;
  logic                r_byte_done;

  logic                w_monitor, w_in_frame, w_tog_step, w_interj;
  logic                w_addr_hit, w_load;
  logic [c_addr_w-1:0] w_addr_byte;

  mbus_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .CLK_IN   (CLK_IN),
    .RESET    (RESET),
    .async_in (BUS_CLK),
    .sync_out (w_sclk),
    .rise     (w_sclk_rise),
    .fall     (w_sclk_fall),
    .change   (w_sclk_chg)
  );

  mbus_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .CLK_IN   (CLK_IN),
    .RESET    (RESET),
    .async_in (BUS_DIN),
    .sync_out (w_sdin),
    .rise     (w_sdin_rise),
    .fall     (w_sdin_fall),
    .change   (w_sdin_chg)
  );

  // Spare strobes of the shared synchroniser are not needed by the receiver.
  assign w_unused_edges = w_sclk_chg ^ w_sdin_rise;

  assign w_monitor   = (r_state == ST_ARB) || (r_state == ST_ADDR) ||
                       (r_state == ST_DATA) || (r_state == ST_IGNORE);
  assign w_in_frame  = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_tog_step  = w_sdin_chg && w_sclk;
  assign w_interj    = w_monitor && w_tog_step && (r_tog_cnt == c_tog_last);
  assign w_addr_byte = {r_shift[c_addr_w-2:0], w_sdin};
  assign w_addr_hit  = (w_addr_byte == NODE_ADDR) || (w_addr_byte == BCAST_ADDR);
  assign w_load      = r_byte_done && (!RX_VALID || RX_READY);
  assign BUSY        = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (w_sdin_fall && w_sclk && (r_idle_cnt == c_idle_max)) w_state_nxt = ST_ARB;
      ST_ARB:
        if (w_interj) w_state_nxt = ST_INTERJ;
        else if (w_sclk_rise && (r_edge_cnt == c_arb_last)) w_state_nxt = ST_ADDR;
      ST_ADDR:
        if (w_interj) w_state_nxt = ST_INTERJ;
        else if (w_sclk_rise && (r_bit_cnt == '1))
          w_state_nxt = w_addr_hit ? ST_DATA : ST_IGNORE;
      ST_DATA, ST_IGNORE:
        if (w_interj) w_state_nxt = ST_INTERJ;
      ST_INTERJ:
        if (r_idle_cnt == c_idle_max) w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      r_idle_cnt  <= '0;
      r_edge_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tog_cnt   <= '0;
      r_shift     <= '0;
      r_byte_done <= 1'b0;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      RX_START    <= 1'b0;
      RX_END      <= 1'b0;
      RX_ERR      <= 1'b0;
    end else begin
      // Idle detection only matters while waiting for a start or for bus release.
      if (((r_state == ST_IDLE) || (r_state == ST_INTERJ)) && w_sclk && w_sdin) begin
        if (r_idle_cnt != c_idle_max) r_idle_cnt <= r_idle_cnt + IW'(1);
      end else begin
        r_idle_cnt <= '0;
      end

      if (r_state != ST_ARB)  r_edge_cnt <= '0;
      else if (w_sclk_rise)   r_edge_cnt <= r_edge_cnt + EW'(1);

      if (!w_in_frame) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
        r_shift   <= w_addr_byte;
      end

      if (!w_monitor || w_sclk_fall) r_tog_cnt <= '0;
      else if (w_tog_step)           r_tog_cnt <= r_tog_cnt + TW'(1);

      r_byte_done <= (r_state == ST_DATA) && w_sclk_rise && (r_bit_cnt == '1);

      if (w_load) begin
        RX_DATA  <= r_shift;
        RX_VALID <= 1'b1;
      end else if (RX_READY) begin
        RX_VALID <= 1'b0;
      end

      RX_START <= (r_state == ST_ADDR) && (w_state_nxt == ST_DATA);
      RX_END   <= w_interj && (r_state == ST_DATA);
      RX_ERR   <= (r_byte_done && !w_load) ||
                  (w_interj && (r_state == ST_DATA) && (r_bit_cnt != '0));
    end
  end

endmodule
`default_nettype wire
